// File: rtl/lpr_cmd_responder_if.sv
// Command/status bundle between the HPS PIO pair, the plate-recognition core and the responder.
// The slave modport is the responder; the master modport is the PIO/core side.
interface lpr_cmd_responder_if;
  logic [31:0] cmd_port;
  logic [31:0] status_port;
  logic [23:0] cfg_out;
  logic        start_pulse;
  logic [23:0] start_arg;
  logic        abort_pulse;
  logic        core_done;
  logic        core_error;

  modport slave (
    input  cmd_port, core_done, core_error,
    output status_port, cfg_out, start_pulse, start_arg, abort_pulse
  );

  modport master (
    output cmd_port, core_done, core_error,
    input  status_port, cfg_out, start_pulse, start_arg, abort_pulse
  );
endinterface

// File: rtl/lpr_cmd_responder.sv
// Decodes tag-sequenced HPS commands into core start/abort/config and reports a status word.
// Two-cycle command latency (register, then decode); core_done/core_error act on the edge they are sampled.
module lpr_cmd_responder #(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 reset,
  lpr_cmd_responder_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_START = 4'd1;
  localparam logic [3:0] OP_ABORT = 4'd2;
  localparam logic [3:0] OP_CFG   = 4'd3;
  localparam logic [3:0] OP_CLR   = 4'd4;

  localparam logic [7:0] ERR_ILLEGAL = 8'h01;
  localparam logic [7:0] ERR_TIMEOUT = 8'h02;
  localparam logic [7:0] ERR_ABORT   = 8'h03;
  localparam logic [7:0] ERR_BUSY    = 8'h04;
  localparam logic [7:0] ERR_CORE    = 8'h05;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    BUSY = 4'd1
  } state_t;

  state_t        state, state_d;
  logic [31:0]   cmd_q;
  logic [3:0]    last_tag, tag_d;
  logic [7:0]    error, err_d;
  logic [15:0]   count, cnt_d;
  logic [23:0]   cfg, cfg_d;
  logic [23:0]   arg, arg_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic          start_r, start_d;
  logic          abort_r, abort_d;

  logic [3:0]  op;
  logic [23:0] cmd_arg;
  logic        new_cmd;

  assign op      = cmd_q[31:28];
  assign cmd_arg = cmd_q[23:0];
  assign new_cmd = (cmd_q[27:24] != last_tag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cmd_q    <= '0;
      last_tag <= '0;
      error    <= '0;
      count    <= '0;
      cfg      <= '0;
      arg      <= '0;
      tcnt     <= '0;
      start_r  <= 1'b0;
      abort_r  <= 1'b0;
    end else begin
      state    <= state_d;
      cmd_q    <= bus.cmd_port;
      last_tag <= tag_d;
      error    <= err_d;
      count    <= cnt_d;
      cfg      <= cfg_d;
      arg      <= arg_d;
      tcnt     <= tcnt_d;
      start_r  <= start_d;
      abort_r  <= abort_d;
    end
  end

  always_comb begin
    state_d = state;
    tag_d   = new_cmd ? cmd_q[27:24] : last_tag;
    err_d   = error;
    cnt_d   = count;
    cfg_d   = cfg;
    arg_d   = arg;
    tcnt_d  = tcnt;
    start_d = 1'b0;
    abort_d = 1'b0;

    case (state)
      IDLE: begin
        if (new_cmd) begin
          case (op)
            OP_START: begin
              arg_d   = cmd_arg;
              start_d = 1'b1;
              tcnt_d  = '0;
              state_d = BUSY;
            end
            OP_CFG:   cfg_d = cmd_arg;
            OP_CLR: begin
              err_d = '0;
              cnt_d = '0;
            end
            OP_NOP, OP_ABORT: ;
            default:  err_d = ERR_ILLEGAL;
          endcase
        end
      end
      BUSY: begin
        tcnt_d = tcnt + 1'b1;
        // A command colliding with done/error is rejected and its code wins.
        if (bus.core_done || bus.core_error) begin
          if (bus.core_done)
            cnt_d = count + 16'd1;
          else
            err_d = ERR_CORE;
          if (new_cmd)
            err_d = ERR_BUSY;
          state_d = IDLE;
        end else if (new_cmd && op == OP_ABORT) begin
          abort_d = 1'b1;
          err_d   = ERR_ABORT;
          state_d = IDLE;
        end else if (tcnt == T_LAST) begin
          abort_d = 1'b1;
          err_d   = ERR_TIMEOUT;
          state_d = IDLE;
        end else if (new_cmd) begin
          err_d = ERR_BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.status_port = {state, last_tag, error, count};
  assign bus.cfg_out     = cfg;
  assign bus.start_arg   = arg;
  assign bus.start_pulse = start_r;
  assign bus.abort_pulse = abort_r;

endmodule

// File: tb/tb_lpr_cmd_responder.sv
// Directed bench for lpr_cmd_responder with a 20-cycle timeout; outputs sampled on the falling edge.
module tb_lpr_cmd_responder;
  logic clk;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   start_seen = 0;
  int   abort_seen = 0;

  lpr_cmd_responder_if bus();

  lpr_cmd_responder #(.TIMEOUT_CYCLES(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.start_pulse === 1'b1) start_seen++;
    if (bus.abort_pulse === 1'b1) abort_seen++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.cmd_port = 32'h0;
    bus.core_done = 1'b0;
    bus.core_error = 1'b0;
    step(3);
    vectors++;
    if (bus.status_port !== 32'h0) begin
      miscompares++; $display("FAIL reset_status got=%h exp=%h", bus.status_port, 32'h0);
    end
    reset = 1'b0;
    step(100);
    #1;
    vectors++;
    if (start_seen !== 0 || abort_seen !== 0) begin
      miscompares++; $display("FAIL reset_pulses got start=%0d abort=%0d exp 0/0", start_seen, abort_seen);
    end
    vectors++;
    if (bus.status_port !== 32'h0 || bus.cfg_out !== 24'h0 || bus.start_arg !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got status=%h cfg=%h arg=%h exp all 0", bus.status_port, bus.cfg_out, bus.start_arg);
    end
  endtask

  task automatic test_set_cfg;
    bus.cmd_port = 32'h3100ABCD;
    step(1);
    vectors++;
    if (bus.cfg_out !== 24'h0) begin
      miscompares++; $display("FAIL cfg_early got=%h exp=%h", bus.cfg_out, 24'h0);
    end
    step(1);
    vectors++;
    if (bus.cfg_out !== 24'h00ABCD) begin
      miscompares++; $display("FAIL cfg_value got=%h exp=%h", bus.cfg_out, 24'h00ABCD);
    end
    vectors++;
    if (bus.status_port !== 32'h01000000) begin
      miscompares++; $display("FAIL cfg_status got=%h exp=%h", bus.status_port, 32'h01000000);
    end
  endtask

  task automatic test_start_done;
    bus.cmd_port = 32'h12000042;
    step(2);
    vectors++;
    if (bus.start_pulse !== 1'b1 || bus.start_arg !== 24'h000042) begin
      miscompares++; $display("FAIL start_pulse got pulse=%b arg=%h exp 1/000042", bus.start_pulse, bus.start_arg);
    end
    vectors++;
    if (bus.status_port !== 32'h12000000) begin
      miscompares++; $display("FAIL start_busy_status got=%h exp=%h", bus.status_port, 32'h12000000);
    end
    step(1);
    vectors++;
    if (bus.start_pulse !== 1'b0) begin
      miscompares++; $display("FAIL start_width got=%b exp=0", bus.start_pulse);
    end
    step(8);
    vectors++;
    if (bus.status_port !== 32'h12000000) begin
      miscompares++; $display("FAIL still_busy got=%h exp=%h", bus.status_port, 32'h12000000);
    end
    bus.core_done = 1'b1;
    step(1);
    bus.core_done = 1'b0;
    #1;
    vectors++;
    if (bus.status_port !== 32'h02000001) begin
      miscompares++; $display("FAIL done_status got=%h exp=%h", bus.status_port, 32'h02000001);
    end
    vectors++;
    if (start_seen !== 1 || abort_seen !== 0) begin
      miscompares++; $display("FAIL done_pulses got start=%0d abort=%0d exp 1/0", start_seen, abort_seen);
    end
  endtask

  task automatic test_busy_reject;
    bus.cmd_port = 32'h10000007;
    step(2);
    vectors++;
    if (bus.status_port !== 32'h10000001) begin
      miscompares++; $display("FAIL reject_busy got=%h exp=%h", bus.status_port, 32'h10000001);
    end
    bus.cmd_port = 32'h33000001;
    step(2);
    vectors++;
    if (bus.cfg_out !== 24'h00ABCD) begin
      miscompares++; $display("FAIL reject_cfg got=%h exp=%h", bus.cfg_out, 24'h00ABCD);
    end
    vectors++;
    if (bus.status_port !== 32'h13040001) begin
      miscompares++; $display("FAIL reject_status got=%h exp=%h", bus.status_port, 32'h13040001);
    end
    bus.cmd_port = 32'h24000000;
    step(2);
    vectors++;
    if (bus.abort_pulse !== 1'b1) begin
      miscompares++; $display("FAIL abort_pulse got=%b exp=1", bus.abort_pulse);
    end
    vectors++;
    if (bus.status_port !== 32'h04030001) begin
      miscompares++; $display("FAIL abort_status got=%h exp=%h", bus.status_port, 32'h04030001);
    end
    step(1);
    vectors++;
    if (bus.abort_pulse !== 1'b0 || bus.start_arg !== 24'h000007) begin
      miscompares++; $display("FAIL abort_after got pulse=%b arg=%h exp 0/000007", bus.abort_pulse, bus.start_arg);
    end
  endtask

  task automatic test_timeout;
    int seen;
    seen = 0;
    bus.cmd_port = 32'h18000010;
    step(2);
    vectors++;
    if (bus.start_pulse !== 1'b1) begin
      miscompares++; $display("FAIL timeout_start got=%b exp=1", bus.start_pulse);
    end
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (bus.abort_pulse === 1'b1) begin
        seen = k;
        break;
      end
    end
    vectors++;
    if (seen !== 20) begin
      miscompares++; $display("FAIL timeout_delay got=%0d exp=20 (0 = never)", seen);
    end
    vectors++;
    if (bus.status_port !== 32'h08020001) begin
      miscompares++; $display("FAIL timeout_status got=%h exp=%h", bus.status_port, 32'h08020001);
    end
  endtask

  task automatic test_illegal_clr_wrap;
    bus.cmd_port = 32'hF5000000;
    step(2);
    vectors++;
    if (bus.status_port !== 32'h05010001) begin
      miscompares++; $display("FAIL illegal_status got=%h exp=%h", bus.status_port, 32'h05010001);
    end
    bus.cmd_port = 32'h46000000;
    step(2);
    vectors++;
    if (bus.status_port !== 32'h06000000) begin
      miscompares++; $display("FAIL clr_status got=%h exp=%h", bus.status_port, 32'h06000000);
    end
    force dut.count = 16'hFFFF;
    step(1);
    release dut.count;
    step(1);
    vectors++;
    if (bus.status_port !== 32'h0600FFFF) begin
      miscompares++; $display("FAIL preload_status got=%h exp=%h", bus.status_port, 32'h0600FFFF);
    end
    bus.cmd_port = 32'h17000000;
    step(2);
    bus.core_done = 1'b1;
    step(1);
    bus.core_done = 1'b0;
    vectors++;
    if (bus.status_port !== 32'h07000000) begin
      miscompares++; $display("FAIL wrap_status got=%h exp=%h", bus.status_port, 32'h07000000);
    end
  endtask

  task automatic test_collisions;
    bus.cmd_port = 32'h19000000;
    step(2);
    bus.cmd_port = 32'h3A000055;
    step(1);
    bus.core_done = 1'b1;
    step(1);
    bus.core_done = 1'b0;
    vectors++;
    if (bus.status_port !== 32'h0A040001 || bus.cfg_out !== 24'h00ABCD) begin
      miscompares++;
      $display("FAIL done_collide got status=%h cfg=%h exp 0a040001/00abcd", bus.status_port, bus.cfg_out);
    end
    bus.cmd_port = 32'h1B000000;
    step(2);
    bus.core_error = 1'b1;
    step(1);
    bus.core_error = 1'b0;
    vectors++;
    if (bus.status_port !== 32'h0B050001) begin
      miscompares++; $display("FAIL core_error got=%h exp=%h", bus.status_port, 32'h0B050001);
    end
    step(5);
    #1;
    vectors++;
    if (start_seen !== 6 || bus.status_port !== 32'h0B050001) begin
      miscompares++; $display("FAIL repeat_tag got start=%0d status=%h exp 6/0b050001", start_seen, bus.status_port);
    end
  endtask

  task automatic test_reset_mid_busy;
    bus.cmd_port = 32'h1C000000;
    step(2);
    #1;
    reset = 1'b1;
    bus.cmd_port = 32'h0;
    #1;
    vectors++;
    if (bus.start_pulse !== 1'b0 || bus.status_port !== 32'h0 || bus.start_arg !== 24'h0) begin
      miscompares++;
      $display("FAIL async_reset got pulse=%b status=%h arg=%h exp 0/0/0", bus.start_pulse, bus.status_port, bus.start_arg);
    end
    step(3);
    reset = 1'b0;
    step(30);
    #1;
    vectors++;
    if (start_seen !== 7 || abort_seen !== 2 || bus.status_port !== 32'h0 || bus.cfg_out !== 24'h0) begin
      miscompares++;
      $display("FAIL post_reset got start=%0d abort=%0d status=%h cfg=%h exp 7/2/0/0",
               start_seen, abort_seen, bus.status_port, bus.cfg_out);
    end
  endtask

  initial begin
    test_reset();
    test_set_cfg();
    test_start_done();
    test_busy_reject();
    test_timeout();
    test_illegal_clr_wrap();
    test_collisions();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lpr_cmd_responder.md
# lpr_cmd_responder

FPGA-side responder for the HPS command PIO. It consumes the 32-bit command word the HPS writes into the output PIO and decodes new commands by sequence tag. It drives start/abort pulses and configuration into the plate-recognition core, tracks completion, timeout and errors, and returns a status word to an HPS-readable input PIO. All logic runs on the single SoC fabric clock.

## Interface
- TIMEOUT_CYCLES, 50000000: maximum cycles in BUSY before a timeout abort (1 s at 50 MHz); must be ≥ 2.
- clk  in  1  fabric clock; same domain as the command PIO.
- reset  in  1  asynchronous, active-high reset.
- cmd_port  in  32  command word from the PIO: [31:28] opcode, [27:24] seq tag, [23:0] argument.
- status_port  out  32  status to the input PIO: [31:28] state code, [27:24] last accepted tag, [23:16] error code, [15:0] completion count.
- cfg_out  out  24  latched configuration word.
- start_pulse  out  1  one-cycle core start strobe.
- start_arg  out  24  argument latched with START; stable until the next START.
- abort_pulse  out  1  one-cycle core abort strobe.
- core_done  in  1  core finished; single-cycle pulse.
- core_error  in  1  core fault; single-cycle pulse.

## Operation
- cmd_q registers cmd_port every cycle. A new command exists when cmd_q[27:24] != last_tag. The HPS changes the tag to issue a command.
- Every new command is accepted exactly once: last_tag <= cmd_q tag in the decode cycle, whether the command executes or is rejected.
- Opcodes: 0 NOP, 1 START, 2 ABORT, 3 SET_CFG, 4 CLR_STATUS. Opcodes 5–15 are illegal.
- State codes: IDLE=0, BUSY=1.
- IDLE with a new command:
  - START: start_arg <= arg; pulse start_pulse; clear the timeout counter; go to BUSY.
  - SET_CFG: cfg_out <= arg.
  - CLR_STATUS: error <= 0 and count <= 0.
  - NOP and ABORT: acknowledge only.
  - Illegal opcode: error <= 0x01.
- BUSY, evaluated in priority order each cycle:
  1. core_done: count <= count+1, wrapping 0xFFFF→0; go to IDLE.
  2. core_error: error <= 0x05; go to IDLE.
  3. New ABORT: pulse abort_pulse; error <= 0x03; go to IDLE.
  4. Timeout counter reaches TIMEOUT_CYCLES-1: pulse abort_pulse; error <= 0x02; go to IDLE.
  5. Any other new command: error <= 0x04 (busy reject); stay in BUSY; cfg_out is unchanged.
- A new command seen in the same cycle as core_done or core_error is still accepted (tag updated) and counts as rejected with error 0x04. The error field then takes 0x04, overriding 0x05.
- The error field holds the most recent error. Only CLR_STATUS or reset clears it.

## Timing
- Reset values: status_port=0, cfg_out=0, start_arg=0, start_pulse=0, abort_pulse=0, cmd_q=0, last_tag=0, state=IDLE, timeout counter=0. Because the PIO also resets to 0, no command fires out of reset.
- Latency:
  - cmd_port changes before edge N; cmd_q updates at edge N.
  - At edge N+1: decode; start_pulse/abort_pulse go high; last_tag, error, cfg_out and state update. start_pulse is high for the cycle after edge N+1 only.
  - status_port is registered and reflects the decode at edge N+1.
- core_done sampled at edge M: state=IDLE and count is incremented at edge M.
- Timeout: abort_pulse is high exactly TIMEOUT_CYCLES cycles after the cycle start_pulse is high, if no done/error/abort occurs first.
- Reset asserted mid-BUSY returns to reset values immediately. Pulses drop asynchronously and no abort_pulse is generated.
- A tag repeated after 16 commands is treated as new only if it differs from last_tag. Wrap-around is legal.

## Test plan
- Reset, cmd_port=0 held for 100 cycles -> no pulses; status_port=0x00000000.
- cmd_port=0x31_00ABCD -> cfg_out=0x00ABCD two edges later; status_port=0x01000000.
- cmd_port=0x12_000042; core_done 10 cycles later -> one start_pulse, start_arg=0x000042, status_port=0x12000000 during BUSY, then 0x02000001.
- START, then cmd_port=0x33_000001 while BUSY -> cfg_out unchanged; error=0x04; tag=3; state BUSY. Then cmd_port=0x24_000000 -> abort_pulse; status_port=0x04030001.
- TIMEOUT_CYCLES=20: START with no done -> abort_pulse exactly 20 cycles after start_pulse; error=0x02; state IDLE.
- Illegal opcode 0xF with tag 5 -> error=0x01; then CLR_STATUS with tag 6 -> status_port=0x06000000; count wraps from 0xFFFF to 0 on the next done.
